// File: rtl/mcycle_controller.sv
// mcycle_controller: multi-cycle fetch/decode/execute controller sharing one
// single-port memory for instruction fetch and load/store data.
// Optional feature: define STEP_MODE_EN to add a single-step HOLD state and
// the step input; without it, retire returns straight to FETCH.
// Handshake: mem_req stays high with stable mem_addr/mem_we until a cycle with
// mem_ready=1; that cycle completes the access. mem_ready is ignored while
// mem_req=0 and outside FETCH/MEM.
module mcycle_controller #(
  parameter int          TIMEOUT  = 15,
  parameter logic [7:0]  PC_RESET = 8'h00
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [7:0] mem_rdata,
  input  logic       mem_ready,
  input  logic [7:0] base_data,
`ifdef STEP_MODE_EN
  input  logic       step,
`endif
  output logic       mem_req,
  output logic       mem_we,
  output logic [7:0] mem_addr,
  output logic [7:0] pc,
  output logic [7:0] ir,
  output logic       reg_write,
  output logic [1:0] reg_wsel,
  output logic       reg_wdata_sel,
  output logic [2:0] state,
  output logic       fault,
  output logic [7:0] retired
);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_FAULT  = 3'd5
`ifdef STEP_MODE_EN
    , S_HOLD = 3'd6
`endif
  } state_t;

  localparam logic [7:0] TIMEOUT_CNT = 8'(TIMEOUT);

  state_t     cur;
  logic [7:0] wait_cnt;
  logic [1:0] op;
  logic [7:0] imm;
  logic [7:0] pc_inc;
  logic [7:0] pc_br;
  logic [7:0] pc_ret;
  logic       mem_done;
  logic       wait_hit;
  logic       retire;

  assign state    = cur;
  assign op       = ir[7:6];
  assign imm      = {{6{ir[1]}}, ir[1:0]};
  assign pc_inc   = pc + 8'd1;
  assign pc_br    = pc + 8'd1 + imm;
  assign pc_ret   = (op == 2'b11) ? pc_br : pc_inc;
  assign mem_done = mem_req & mem_ready;
  // The cycle whose miss would bring the wait count up to TIMEOUT faults,
  // unless mem_ready arrives in that same cycle.
  assign wait_hit = mem_req & ~mem_ready & ((wait_cnt + 8'd1) == TIMEOUT_CNT);
  assign retire   = ((cur == S_EXEC) && ((op == 2'b00) || (op == 2'b11))) ||
                    ((cur == S_MEM) && mem_done && (op == 2'b10)) ||
                    (cur == S_WB);

  // Controller FSM; every output is registered and set for the state being entered.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      cur           <= S_FETCH;
      pc            <= PC_RESET;
      ir            <= 8'h00;
      retired       <= 8'h00;
      fault         <= 1'b0;
      wait_cnt      <= 8'h00;
      mem_req       <= 1'b0;
      mem_we        <= 1'b0;
      mem_addr      <= PC_RESET;
      reg_write     <= 1'b0;
      reg_wsel      <= 2'b00;
      reg_wdata_sel <= 1'b0;
    end else begin
      reg_write <= 1'b0;
      case (cur)
        S_FETCH: begin
          if (mem_done) begin
            ir      <= mem_rdata;
            mem_req <= 1'b0;
            cur     <= S_DECODE;
          end else if (wait_hit) begin
            mem_req <= 1'b0;
            mem_we  <= 1'b0;
            fault   <= 1'b1;
            cur     <= S_FAULT;
          end else if (mem_req) begin
            wait_cnt <= wait_cnt + 8'd1;
          end else begin
            // First cycle out of reset: raise the fetch request.
            mem_req  <= 1'b1;
            mem_we   <= 1'b0;
            mem_addr <= pc;
            wait_cnt <= 8'h00;
          end
        end
        S_DECODE: begin
          cur <= S_EXEC;
          if (op == 2'b00) begin
            reg_write     <= 1'b1;
            reg_wsel      <= ir[1:0];
            reg_wdata_sel <= 1'b0;
          end
        end
        S_EXEC: begin
          if ((op == 2'b01) || (op == 2'b10)) begin
            mem_req  <= 1'b1;
            mem_we   <= (op == 2'b10);
            mem_addr <= base_data + imm;
            wait_cnt <= 8'h00;
            cur      <= S_MEM;
          end
        end
        S_MEM: begin
          if (mem_done) begin
            mem_req <= 1'b0;
            mem_we  <= 1'b0;
            if (op == 2'b01) begin
              reg_write     <= 1'b1;
              reg_wsel      <= ir[3:2];
              reg_wdata_sel <= 1'b1;
              cur           <= S_WB;
            end
          end else if (wait_hit) begin
            mem_req <= 1'b0;
            mem_we  <= 1'b0;
            fault   <= 1'b1;
            cur     <= S_FAULT;
          end else begin
            wait_cnt <= wait_cnt + 8'd1;
          end
        end
        S_WB: begin
          cur <= S_WB;
        end
        S_FAULT: begin
          cur <= S_FAULT;
        end
`ifdef STEP_MODE_EN
        S_HOLD: begin
          if (step) begin
            mem_req  <= 1'b1;
            mem_we   <= 1'b0;
            mem_addr <= pc;
            wait_cnt <= 8'h00;
            cur      <= S_FETCH;
          end
        end
`endif
        default: begin
          cur <= S_FETCH;
        end
      endcase

      // Retire overrides the per-state updates above.
      if (retire) begin
        pc       <= pc_ret;
        retired  <= retired + 8'd1;
        mem_addr <= pc_ret;
        mem_we   <= 1'b0;
        wait_cnt <= 8'h00;
`ifdef STEP_MODE_EN
        mem_req  <= 1'b0;
        cur      <= S_HOLD;
`else
        mem_req  <= 1'b1;
        cur      <= S_FETCH;
`endif
      end
    end
  end

endmodule

// File: tb/tb_mcycle_controller.sv
// Directed testbench for mcycle_controller; inputs change and outputs are
// sampled on the falling clock edge.
module tb_mcycle_controller;

  logic       clock;
  logic       reset;
  logic [7:0] mem_rdata;
  logic       mem_ready;
  logic [7:0] base_data;
  logic       step;
  logic       mem_req;
  logic       mem_we;
  logic [7:0] mem_addr;
  logic [7:0] pc;
  logic [7:0] ir;
  logic       reg_write;
  logic [1:0] reg_wsel;
  logic       reg_wdata_sel;
  logic [2:0] state;
  logic       fault;
  logic [7:0] retired;

  int checks   = 0;
  int failures = 0;

  mcycle_controller #(.TIMEOUT(15), .PC_RESET(8'h00)) dut (
    .clock         (clock),
    .reset         (reset),
    .mem_rdata     (mem_rdata),
    .mem_ready     (mem_ready),
    .base_data     (base_data),
`ifdef STEP_MODE_EN
    .step          (step),
`endif
    .mem_req       (mem_req),
    .mem_we        (mem_we),
    .mem_addr      (mem_addr),
    .pc            (pc),
    .ir            (ir),
    .reg_write     (reg_write),
    .reg_wsel      (reg_wsel),
    .reg_wdata_sel (reg_wdata_sel),
    .state         (state),
    .fault         (fault),
    .retired       (retired)
  );

  // clock
  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clock);
    @(negedge clock);
  endtask

  // Called right after a retire edge; in step mode walks through HOLD.
  task automatic after_retire();
`ifdef STEP_MODE_EN
    chk("hold_state", state, 32'd6);
    chk("hold_req", mem_req, 32'd0);
    cyc();
    chk("hold_stay", state, 32'd6);
    chk("hold_stay_req", mem_req, 32'd0);
    step = 1'b1;
    cyc();
    step = 1'b0;
`endif
  endtask

  // Run an op-00 instruction from a FETCH cycle with mem_req already high.
  task automatic run_alu(input logic [7:0] instr);
    mem_ready = 1'b1;
    mem_rdata = instr;
    cyc();
    mem_ready = 1'b0;
    cyc();
    cyc();
    after_retire();
  endtask

  initial begin
    reset     = 1'b0;
    step      = 1'b0;
    mem_ready = 1'b0;
    mem_rdata = 8'h00;
    base_data = 8'h00;
    cyc();
    chk("rst_state", state, 32'd0);
    chk("rst_pc", pc, 32'h00);
    chk("rst_ir", ir, 32'h00);
    chk("rst_retired", retired, 32'd0);
    chk("rst_fault", fault, 32'd0);
    chk("rst_req", mem_req, 32'd0);
    chk("rst_we", mem_we, 32'd0);
    chk("rst_rw", reg_write, 32'd0);

    reset = 1'b1;
    cyc();
    chk("first_req", mem_req, 32'd1);
    chk("first_addr", mem_addr, 32'h00);

    // op 00: 8'h1B writes register 3 from the adder
    mem_ready = 1'b1;
    mem_rdata = 8'h1B;
    cyc();
    chk("alu_decode", state, 32'd1);
    chk("alu_ir", ir, 32'h1B);
    chk("alu_dec_req", mem_req, 32'd0);
    chk("alu_dec_rw", reg_write, 32'd0);
    mem_ready = 1'b0;
    cyc();
    chk("alu_exec", state, 32'd2);
    chk("alu_rw", reg_write, 32'd1);
    chk("alu_wsel", reg_wsel, 32'd3);
    chk("alu_wdsel", reg_wdata_sel, 32'd0);
    cyc();
    chk("alu_pc", pc, 32'h01);
    chk("alu_retired", retired, 32'd1);
    chk("alu_rw_off", reg_write, 32'd0);
    after_retire();
    chk("alu_fetch", state, 32'd0);
    chk("alu_next_req", mem_req, 32'd1);
    chk("alu_next_addr", mem_addr, 32'h01);

    for (int i = 0; i < 4; i++) run_alu(8'h00);
    chk("pad_pc", pc, 32'h05);

    // branch 8'hC2, imm=-2: 5+1-2 = 4
    mem_ready = 1'b1;
    mem_rdata = 8'hC2;
    cyc();
    chk("br_dec_rw", reg_write, 32'd0);
    mem_ready = 1'b0;
    cyc();
    chk("br_exec", state, 32'd2);
    chk("br_exec_rw", reg_write, 32'd0);
    cyc();
    chk("br_pc", pc, 32'h04);
    chk("br_retired", retired, 32'd6);
    chk("br_rw", reg_write, 32'd0);
    after_retire();
    chk("br_fetch_addr", mem_addr, 32'h04);

    // load 8'h5D, base 8'h10, imm=+1 -> address 8'h11, writes register 3
    base_data = 8'h10;
    mem_ready = 1'b1;
    mem_rdata = 8'h5D;
    cyc();
    mem_ready = 1'b0;
    cyc();
    cyc();
    chk("ld_mem", state, 32'd3);
    chk("ld_req", mem_req, 32'd1);
    chk("ld_addr", mem_addr, 32'h11);
    chk("ld_we", mem_we, 32'd0);
    cyc();
    chk("ld_wait_state", state, 32'd3);
    chk("ld_wait_addr", mem_addr, 32'h11);
    chk("ld_wait_req", mem_req, 32'd1);
    mem_ready = 1'b1;
    mem_rdata = 8'hAA;
    cyc();
    chk("ld_wb", state, 32'd4);
    chk("ld_rw", reg_write, 32'd1);
    chk("ld_wsel", reg_wsel, 32'd3);
    chk("ld_wdsel", reg_wdata_sel, 32'd1);
    chk("ld_wb_req", mem_req, 32'd0);
    mem_ready = 1'b0;
    cyc();
    chk("ld_pc", pc, 32'h05);
    chk("ld_retired", retired, 32'd7);
    chk("ld_rw_off", reg_write, 32'd0);
    after_retire();
    chk("ld_fetch", state, 32'd0);

    // store 8'h9E, base 8'h00, imm=-2 -> address 8'hFE; ready held high
    // through DECODE/EXEC where it must be ignored
    base_data = 8'h00;
    mem_ready = 1'b1;
    mem_rdata = 8'h9E;
    cyc();
    chk("st_decode", state, 32'd1);
    chk("st_dec_rw", reg_write, 32'd0);
    cyc();
    chk("st_exec", state, 32'd2);
    chk("st_exec_rw", reg_write, 32'd0);
    cyc();
    chk("st_mem", state, 32'd3);
    chk("st_addr", mem_addr, 32'hFE);
    chk("st_we", mem_we, 32'd1);
    chk("st_req", mem_req, 32'd1);
    chk("st_mem_rw", reg_write, 32'd0);
    cyc();
    chk("st_pc", pc, 32'h06);
    chk("st_retired", retired, 32'd8);
    chk("st_rw", reg_write, 32'd0);
    chk("st_we_off", mem_we, 32'd0);
    mem_ready = 1'b0;
    after_retire();
    chk("st_fetch", state, 32'd0);
    chk("st_fetch_addr", mem_addr, 32'h06);

    // fetch timeout: 15 missed cycles fault
    repeat (14) cyc();
    chk("to_pre_state", state, 32'd0);
    chk("to_pre_fault", fault, 32'd0);
    chk("to_pre_req", mem_req, 32'd1);
    cyc();
    chk("to_state", state, 32'd5);
    chk("to_fault", fault, 32'd1);
    chk("to_req", mem_req, 32'd0);
    chk("to_we", mem_we, 32'd0);
    chk("to_pc", pc, 32'h06);
    chk("to_retired", retired, 32'd8);
    mem_ready = 1'b1;
    repeat (3) cyc();
    chk("flt_state", state, 32'd5);
    chk("flt_pc", pc, 32'h06);
    chk("flt_ir", ir, 32'h9E);
    chk("flt_req", mem_req, 32'd0);
    mem_ready = 1'b0;
    reset = 1'b0;
    #1;
    chk("rst2_fault", fault, 32'd0);
    chk("rst2_state", state, 32'd0);
    chk("rst2_pc", pc, 32'h00);
    chk("rst2_retired", retired, 32'd0);
    chk("rst2_req", mem_req, 32'd0);
    reset = 1'b1;
    cyc();
    chk("rst2_first_req", mem_req, 32'd1);

    // ready on the cycle the count would reach TIMEOUT: completion wins
    repeat (14) cyc();
    chk("edge_pre_state", state, 32'd0);
    mem_ready = 1'b1;
    mem_rdata = 8'h00;
`ifdef STEP_MODE_EN
    step = 1'b1;
`endif
    cyc();
    step = 1'b0;
    chk("edge_state", state, 32'd1);
    chk("edge_fault", fault, 32'd0);
    mem_ready = 1'b0;
    cyc();
    cyc();
    chk("edge_pc", pc, 32'h01);
    chk("edge_retired", retired, 32'd1);
    after_retire();
    chk("edge_fetch", state, 32'd0);
    chk("edge_fetch_req", mem_req, 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
